// File: rtl/kalman_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : kalman_sequencer
//  Purpose  : Initiator/controller for the three-axis Kalman ALU. Holds the
//             latest gyro and accelerometer samples, measures elapsed time as
//             dt, launches an ALU update (load_gyro, settle, axis enables),
//             captures the updated angles and presents them on a valid/ready
//             handshake.
//  Ports    :
//    clk, n_rst                       clock, asynchronous active-low reset
//    gyro_valid, gyro_in[47:0]        gyro sample strobe/data (roll/pitch/yaw)
//    acc_valid, acc_pitch/yaw/roll    accelerometer sample strobe/data
//    alu_gyro_data, alu_dt,
//    alu_pitch/yaw/roll_meas          operands driven to the ALU
//    load_gyro, pitch/yaw/roll_en     ALU strobes
//    alu_pitch/yaw/roll               ALU result registers
//    att_valid, att_ready,
//    att_pitch/yaw/roll               downstream attitude handshake
//    busy                             high whenever not IDLE
//    overrun                          sticky: a held sample was overwritten
//  Revision : 1.0 - initial release
// ============================================================================
module kalman_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int DT_DIV        = 1000
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        gyro_valid,
   input  logic [47:0] gyro_in,
   input  logic        acc_valid,
   input  logic [15:0] acc_pitch,
   input  logic [15:0] acc_yaw,
   input  logic [15:0] acc_roll,
   output logic [47:0] alu_gyro_data,
   output logic [7:0]  alu_dt,
   output logic [15:0] alu_pitch_meas,
   output logic [15:0] alu_yaw_meas,
   output logic [15:0] alu_roll_meas,
   output logic        load_gyro,
   output logic        pitch_en,
   output logic        yaw_en,
   output logic        roll_en,
   input  logic [15:0] alu_pitch,
   input  logic [15:0] alu_yaw,
   input  logic [15:0] alu_roll,
   output logic        att_valid,
   input  logic        att_ready,
   output logic [15:0] att_pitch,
   output logic [15:0] att_yaw,
   output logic [15:0] att_roll,
   output logic        busy,
   output logic        overrun
);

   localparam int             c_PRESC_W     = (DT_DIV > 1) ? $clog2(DT_DIV) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(DT_DIV - 1);
   localparam logic [7:0]     c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0]     c_DT_MAX      = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_SETTLE  = 3'd2,
      S_UPDATE  = 3'd3,
      S_CAPTURE = 3'd4,
      S_PRESENT = 3'd5
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [47:0]          r_gyro_hold;
   logic [15:0]          r_acc_pitch_hold;
   logic [15:0]          r_acc_yaw_hold;
   logic [15:0]          r_acc_roll_hold;
   logic                 r_gyro_seen;
   logic                 r_acc_seen;
   logic                 r_overrun;
   logic [c_PRESC_W-1:0] r_presc;
   logic [7:0]           r_dt_cnt;
   logic [7:0]           r_settle_cnt;
   logic [47:0]          r_alu_gyro_data;
   logic [7:0]           r_alu_dt;
   logic [15:0]          r_alu_pitch_meas;
   logic [15:0]          r_alu_yaw_meas;
   logic [15:0]          r_alu_roll_meas;
   logic [15:0]          r_att_pitch;
   logic [15:0]          r_att_yaw;
   logic [15:0]          r_att_roll;

   logic w_in_load;
   logic w_settle_done;

   assign w_in_load     = (r_state == S_LOAD);
   assign w_settle_done = (r_settle_cnt == c_SETTLE_LAST);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and strobe decode. Strobes are pure state decodes so they
   // drop to 0 the instant reset is asserted.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      load_gyro    = 1'b0;
      pitch_en     = 1'b0;
      yaw_en       = 1'b0;
      roll_en      = 1'b0;
      att_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            // Only registered flags count; a same-cycle strobe waits a cycle.
            if (r_gyro_seen && r_acc_seen) begin
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            load_gyro    = 1'b1;
            w_state_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (w_settle_done) begin
               w_state_next = S_UPDATE;
            end
         end
         S_UPDATE: begin
            pitch_en     = 1'b1;
            yaw_en       = 1'b1;
            roll_en      = 1'b1;
            w_state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_state_next = S_PRESENT;
         end
         S_PRESENT: begin
            att_valid = 1'b1;
            if (att_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Sample holding, overrun detection, dt measurement, ALU operand and
   // attitude capture registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_gyro_hold      <= '0;
         r_acc_pitch_hold <= '0;
         r_acc_yaw_hold   <= '0;
         r_acc_roll_hold  <= '0;
         r_gyro_seen      <= 1'b0;
         r_acc_seen       <= 1'b0;
         r_overrun        <= 1'b0;
         r_presc          <= '0;
         r_dt_cnt         <= '0;
         r_settle_cnt     <= '0;
         r_alu_gyro_data  <= '0;
         r_alu_dt         <= '0;
         r_alu_pitch_meas <= '0;
         r_alu_yaw_meas   <= '0;
         r_alu_roll_meas  <= '0;
         r_att_pitch      <= '0;
         r_att_yaw        <= '0;
         r_att_roll       <= '0;
      end else begin
         // A strobe during LOAD refills the slot being consumed, so it is a
         // fresh sample rather than an overwrite of an unused one.
         if (gyro_valid) begin
            r_gyro_hold <= gyro_in;
            r_gyro_seen <= 1'b1;
            if (r_gyro_seen && !w_in_load) begin
               r_overrun <= 1'b1;
            end
         end else if (w_in_load) begin
            r_gyro_seen <= 1'b0;
         end

         if (acc_valid) begin
            r_acc_pitch_hold <= acc_pitch;
            r_acc_yaw_hold   <= acc_yaw;
            r_acc_roll_hold  <= acc_roll;
            r_acc_seen       <= 1'b1;
            if (r_acc_seen && !w_in_load) begin
               r_overrun <= 1'b1;
            end
         end else if (w_in_load) begin
            r_acc_seen <= 1'b0;
         end

         // dt restarts at every LOAD; a tick landing on that cycle is lost.
         if (w_in_load) begin
            r_presc  <= '0;
            r_dt_cnt <= '0;
         end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            if (r_dt_cnt != c_DT_MAX) begin
               r_dt_cnt <= r_dt_cnt + 8'd1;
            end
         end else begin
            r_presc <= r_presc + 1'b1;
         end

         if (r_state == S_SETTLE && !w_settle_done) begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
         end else begin
            r_settle_cnt <= '0;
         end

         // Operands are only written here, so they stay frozen for the rest
         // of the update.
         if (w_in_load) begin
            r_alu_gyro_data  <= r_gyro_hold;
            r_alu_pitch_meas <= r_acc_pitch_hold;
            r_alu_yaw_meas   <= r_acc_yaw_hold;
            r_alu_roll_meas  <= r_acc_roll_hold;
            r_alu_dt         <= r_dt_cnt;
         end

         if (r_state == S_CAPTURE) begin
            r_att_pitch <= alu_pitch;
            r_att_yaw   <= alu_yaw;
            r_att_roll  <= alu_roll;
         end
      end
   end

   assign alu_gyro_data  = r_alu_gyro_data;
   assign alu_dt         = r_alu_dt;
   assign alu_pitch_meas = r_alu_pitch_meas;
   assign alu_yaw_meas   = r_alu_yaw_meas;
   assign alu_roll_meas  = r_alu_roll_meas;
   assign att_pitch      = r_att_pitch;
   assign att_yaw        = r_att_yaw;
   assign att_roll       = r_att_roll;
   assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_kalman_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kalman_sequencer
//  Purpose  : Directed self-checking bench for kalman_sequencer
//             (SETTLE_CYCLES=4, DT_DIV=10). The ALU results are driven
//             directly by the bench as constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kalman_sequencer;

   logic        clk;
   logic        n_rst;
   logic        gyro_valid;
   logic [47:0] gyro_in;
   logic        acc_valid;
   logic [15:0] acc_pitch, acc_yaw, acc_roll;
   logic [47:0] alu_gyro_data;
   logic [7:0]  alu_dt;
   logic [15:0] alu_pitch_meas, alu_yaw_meas, alu_roll_meas;
   logic        load_gyro, pitch_en, yaw_en, roll_en;
   logic [15:0] alu_pitch, alu_yaw, alu_roll;
   logic        att_valid, att_ready;
   logic [15:0] att_pitch, att_yaw, att_roll;
   logic        busy, overrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t_load = 0;

   kalman_sequencer #(.SETTLE_CYCLES(4), .DT_DIV(10)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .gyro_valid     (gyro_valid),
      .gyro_in        (gyro_in),
      .acc_valid      (acc_valid),
      .acc_pitch      (acc_pitch),
      .acc_yaw        (acc_yaw),
      .acc_roll       (acc_roll),
      .alu_gyro_data  (alu_gyro_data),
      .alu_dt         (alu_dt),
      .alu_pitch_meas (alu_pitch_meas),
      .alu_yaw_meas   (alu_yaw_meas),
      .alu_roll_meas  (alu_roll_meas),
      .load_gyro      (load_gyro),
      .pitch_en       (pitch_en),
      .yaw_en         (yaw_en),
      .roll_en        (roll_en),
      .alu_pitch      (alu_pitch),
      .alu_yaw        (alu_yaw),
      .alu_roll       (alu_roll),
      .att_valid      (att_valid),
      .att_ready      (att_ready),
      .att_pitch      (att_pitch),
      .att_yaw        (att_yaw),
      .att_roll       (att_roll),
      .busy           (busy),
      .overrun        (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling and driving happen 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drive the strobes during the current cycle, then advance one clock.
   task automatic pulse(input logic g, input logic a, input logic [47:0] gd,
                        input logic [15:0] ap, input logic [15:0] ay, input logic [15:0] ar);
      gyro_valid = g;
      acc_valid  = a;
      gyro_in    = gd;
      acc_pitch  = ap;
      acc_yaw    = ay;
      acc_roll   = ar;
      tick();
      gyro_valid = 1'b0;
      acc_valid  = 1'b0;
   endtask

   // Called one cycle after the completing strobe; ends in the first
   // PRESENT cycle. LOAD is expected next cycle, enables LOAD+5, valid LOAD+7.
   task automatic check_run(input string tag, input logic [47:0] eg,
                            input logic [47:0] emeas, input logic do_dt,
                            input logic [7:0] edt, input logic [47:0] eatt);
      chk({tag, " pre_load"}, load_gyro, 1'b0);
      tick();
      chk({tag, " load_gyro"}, {load_gyro, pitch_en, yaw_en, roll_en, busy}, 5'b1_000_1);
      t_load = cyc;
      tick();
      chk({tag, " gyro_data"}, alu_gyro_data, eg);
      chk({tag, " meas"}, {alu_pitch_meas, alu_yaw_meas, alu_roll_meas}, emeas);
      if (do_dt) chk({tag, " dt"}, alu_dt, edt);
      repeat (3) tick();
      chk({tag, " settle_end"}, {load_gyro, pitch_en, yaw_en, roll_en, att_valid}, 5'b0);
      tick();
      chk({tag, " enables"}, {load_gyro, pitch_en, yaw_en, roll_en}, 4'b0111);
      tick();
      chk({tag, " capture"}, {att_valid, pitch_en}, 2'b00);
      tick();
      chk({tag, " att_valid"}, att_valid, 1'b1);
      chk({tag, " att_data"}, {att_pitch, att_yaw, att_roll}, eatt);
   endtask

   initial begin
      logic seen_activity;
      n_rst      = 1'b0;
      gyro_valid = 1'b0;
      acc_valid  = 1'b0;
      gyro_in    = '0;
      acc_pitch  = '0;
      acc_yaw    = '0;
      acc_roll   = '0;
      alu_pitch  = '0;
      alu_yaw    = '0;
      alu_roll   = '0;
      att_ready  = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst strobes", {load_gyro, pitch_en, yaw_en, roll_en, att_valid, busy, overrun}, 7'b0);
      chk("rst alu", {alu_gyro_data, alu_dt}, 56'h0);
      chk("rst att", {att_pitch, att_yaw, att_roll}, 48'h0);
      n_rst = 1'b1;
      tick();

      // 1: basic sequence
      alu_pitch = 16'h0123; alu_yaw = 16'h0456; alu_roll = 16'h0789;
      pulse(1'b1, 1'b1, 48'h1111_2222_3333, 16'hA001, 16'hA002, 16'hA003);
      check_run("t1", 48'h1111_2222_3333, 48'hA001_A002_A003, 1'b0, 8'h0, 48'h0123_0456_0789);
      tick();
      chk("t1 idle", {att_valid, busy}, 2'b00);

      // 2: dt = 3 for 37 cycles between LOADs, then saturation
      alu_pitch = 16'h1001; alu_yaw = 16'h1002; alu_roll = 16'h1003;
      while (cyc < t_load + 35) tick();
      pulse(1'b1, 1'b1, 48'h4444_5555_6666, 16'hB001, 16'hB002, 16'hB003);
      check_run("t2a", 48'h4444_5555_6666, 48'hB001_B002_B003, 1'b1, 8'd3, 48'h1001_1002_1003);
      tick();
      while (cyc < t_load + 2998) tick();
      pulse(1'b1, 1'b1, 48'h7777_8888_9999, 16'hC001, 16'hC002, 16'hC003);
      check_run("t2b", 48'h7777_8888_9999, 48'hC001_C002_C003, 1'b1, 8'd255, 48'h1001_1002_1003);
      tick();

      // 3: backpressure for 20 cycles in PRESENT
      att_ready = 1'b0;
      alu_pitch = 16'h2001; alu_yaw = 16'h2002; alu_roll = 16'h2003;
      pulse(1'b1, 1'b1, 48'hAAAA_BBBB_CCCC, 16'hD001, 16'hD002, 16'hD003);
      check_run("t3", 48'hAAAA_BBBB_CCCC, 48'hD001_D002_D003, 1'b0, 8'h0, 48'h2001_2002_2003);
      for (int i = 0; i < 19; i++) begin
         alu_pitch = 16'h3000 + 16'(i);
         alu_yaw   = 16'h4000 + 16'(i);
         alu_roll  = 16'h5000 + 16'(i);
         tick();
         chk("t3 hold", {att_valid, att_pitch, att_yaw, att_roll}, {1'b1, 48'h2001_2002_2003});
      end
      att_ready = 1'b1;
      tick();
      chk("t3 accept", {att_valid, busy}, 2'b00);

      // 4: gyro only for 100 cycles, then acc completes the pair
      pulse(1'b1, 1'b0, 48'h0102_0304_0506, 16'h0, 16'h0, 16'h0);
      seen_activity = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         seen_activity = seen_activity | load_gyro | busy;
      end
      chk("t4 quiet", seen_activity, 1'b0);
      alu_pitch = 16'h6001; alu_yaw = 16'h6002; alu_roll = 16'h6003;
      pulse(1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 16'hE001, 16'hE002, 16'hE003);
      check_run("t4", 48'h0102_0304_0506, 48'hE001_E002_E003, 1'b0, 8'h0, 48'h6001_6002_6003);
      tick();
      chk("t4 no_overrun", overrun, 1'b0);

      // 5: two gyro strobes before acc -> overrun, second sample used
      pulse(1'b1, 1'b0, 48'h0000_0000_00A1, 16'h0, 16'h0, 16'h0);
      chk("t5 first", overrun, 1'b0);
      pulse(1'b1, 1'b0, 48'h0000_0000_00A2, 16'h0, 16'h0, 16'h0);
      chk("t5 overrun", overrun, 1'b1);
      pulse(1'b0, 1'b1, 48'h0, 16'hF001, 16'hF002, 16'hF003);
      check_run("t5", 48'h0000_0000_00A2, 48'hF001_F002_F003, 1'b0, 8'h0, 48'h6001_6002_6003);
      tick();
      chk("t5 sticky", overrun, 1'b1);

      // 6: reset during SETTLE
      pulse(1'b1, 1'b1, 48'h1234_5678_9ABC, 16'h1111, 16'h2222, 16'h3333);
      tick();
      chk("t6 load", load_gyro, 1'b1);
      tick();
      tick();
      n_rst = 1'b0;
      #1;
      chk("t6 rst outs", {busy, load_gyro, pitch_en, yaw_en, roll_en, att_valid, overrun}, 7'b0);
      chk("t6 rst alu", alu_gyro_data, 48'h0);
      tick();
      n_rst = 1'b1;
      tick();
      chk("t6 idle", busy, 1'b0);
      alu_pitch = 16'h7001; alu_yaw = 16'h7002; alu_roll = 16'h7003;
      pulse(1'b1, 1'b1, 48'hCAFE_BABE_F00D, 16'h4444, 16'h5555, 16'h6666);
      check_run("t6", 48'hCAFE_BABE_F00D, 48'h4444_5555_6666, 1'b0, 8'h0, 48'h7001_7002_7003);
      tick();
      chk("t6 done", {att_valid, busy, overrun}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/kalman_sequencer.md
Name: kalman_sequencer

Overview:
Initiator/controller for the three-axis Kalman ALU. Collects gyro and accelerometer samples and measures elapsed time as dt. Drives the ALU's load_gyro and pitch_en/yaw_en/roll_en strobes with settle timing for its deep combinational path. Captures the updated pitch/yaw/roll angles and presents them downstream on a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 4, cycles waited after load_gyro before asserting the axis enables; legal range 1..255.
DT_DIV, 1000, clk cycles per dt tick; legal range >= 1.

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
gyro_valid  in  1  one-cycle strobe; gyro_in valid
gyro_in  in  48  [15:0] roll, [31:16] pitch, [47:32] yaw rate
acc_valid  in  1  one-cycle strobe; acc_* valid
acc_pitch / acc_yaw / acc_roll  in  16 each  accelerometer angles
alu_gyro_data  out  48  to ALU gyro_data
alu_dt  out  8  to ALU dt_in
alu_pitch_meas / alu_yaw_meas / alu_roll_meas  out  16 each  to ALU new_angle_in / yaw_data / roll_data
load_gyro  out  1  to ALU
pitch_en / yaw_en / roll_en  out  1 each  to ALU
alu_pitch / alu_yaw / alu_roll  in  16 each  from ALU pitch_out / yaw_out / roll_out
att_valid  out  1  result valid
att_ready  in  1  downstream accept
att_pitch / att_yaw / att_roll  out  16 each  captured angles
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; a held sample was overwritten before use

Behaviour:
- Reset: all outputs 0; internal holding regs, flags and counters 0; state IDLE.
- Holding regs: gyro_valid writes gyro_in to gyro_hold and sets gyro_seen. acc_valid writes acc_* to acc_hold and sets acc_seen. Both are accepted in any state.
- Overwrite: a valid arriving while its seen flag is already 1 sets overrun, which stays set until reset.
- dt timing: a prescaler counts 0..DT_DIV-1. On wrap, dt_cnt increments and saturates at 255.
- FSM states: IDLE, LOAD, SETTLE, UPDATE, CAPTURE, PRESENT.
- IDLE: when registered gyro_seen && acc_seen, go to LOAD next cycle. A same-cycle valid does not count.
- LOAD (1 cycle):
  - load_gyro=1.
  - alu_gyro_data<=gyro_hold; alu_*_meas<=acc_hold; alu_dt<=dt_cnt.
  - dt_cnt and prescaler cleared to 0. A coincident tick is discarded.
  - gyro_seen/acc_seen cleared, unless a new valid arrives that same cycle; then the flag stays 1 and overrun is not set.
  - Then go to SETTLE.
- SETTLE: counts exactly SETTLE_CYCLES cycles, then UPDATE.
- alu_* outputs: held constant from LOAD through CAPTURE.
- UPDATE (1 cycle): pitch_en=yaw_en=roll_en=1, then CAPTURE.
- CAPTURE (1 cycle): att_pitch/yaw/roll <= alu_pitch/yaw/roll, which are the post-update ALU registers. Then PRESENT.
- PRESENT:
  - att_valid=1; att_* stable until handshake.
  - On att_valid && att_ready, go to IDLE next cycle with att_valid=0.
  - att_ready is ignored in every other state.
  - Samples arriving meanwhile are held; a pending pair starts LOAD right after returning to IDLE.
- Latency: if LOAD is cycle T, enables are high in T+SETTLE_CYCLES+1 and att_valid rises in T+SETTLE_CYCLES+3.
- Strobe rules: load_gyro and the enables are single-cycle pulses, never asserted together or outside LOAD/UPDATE.
- Width: no arithmetic beyond the counters; dt saturates and never wraps.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. A partially started ALU update is abandoned; the ALU has its own reset.

Test Plan:
1. SETTLE_CYCLES=4, DT_DIV=10. Reset, gyro_valid and acc_valid together, ALU model returns 16'h0123/16'h0456/16'h0789, att_ready=1 -> load_gyro 2 cycles after the strobes; enables 5 cycles after load_gyro; att_valid 2 cycles after enables with those three values; then IDLE.
2. dt measurement: 37 cycles between successive LOADs with DT_DIV=10 -> alu_dt=3. A 3000-cycle gap -> alu_dt=255 (saturated).
3. Backpressure: hold att_ready=0 for 20 cycles in PRESENT, changing alu_* inputs meanwhile -> att_valid stays 1 and att_* unchanged; accepted on the first att_ready=1 cycle.
4. Only gyro_valid, no acc_valid for 100 cycles -> no load_gyro, busy=0. A later acc_valid starts the sequence using the original gyro sample.
5. Two gyro_valid strobes before acc_valid -> overrun=1 and persists; LOAD uses the second gyro sample.
6. Reset asserted during SETTLE -> busy, load_gyro, enables, att_valid and overrun all 0 immediately. After release, a fresh sample pair gives normal timing.
